axis_width_upsizer: RTL and testbench

//   AXI-stream receiver-to-transmitter width converter. Consumes a narrow stream on an
//   axi_stream_if slave port and packs RATIO consecutive beats into one wide beat on an
//   axi_stream_if master port. tlast closes a wide word early.

---
 rtl/axis_pkg.sv | 11 +
 rtl/axi_stream_if.sv | 14 +
 rtl/axis_out_reg.sv | 40 ++++
 rtl/axis_width_upsizer.sv | 80 ++++++++
 tb/tb_axis_width_upsizer.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// Shared constants and helpers for the AXI-stream width converters.
package axis_pkg;

  localparam int AXIS_BYTE_W = 8;

  // Width of a "beats in word" count able to hold 0..ratio.
  function automatic int nbeats_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-stream bundle: tvalid/tdata/tlast forward, tready backward.
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/axis_out_reg.sv
// One-entry registered output stage: holds data/last/nbeats until accepted,
// and can reload on the same cycle it drains so full rate is kept.
module axis_out_reg #(
  parameter int DATA_W = 32,
  parameter int NB_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [NB_W-1:0]   in_nbeats,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [NB_W-1:0]   out_nbeats,
  input  logic              out_ready
);

  // Ready-through: an empty slot or one draining this cycle can take a new entry.
  assign in_ready = !rst && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_nbeats <= '0;
    end else if (in_valid && in_ready) begin
      out_valid  <= 1'b1;
      out_data   <= in_data;
      out_last   <= in_last;
      out_nbeats <= in_nbeats;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_width_upsizer.sv
// Packs RATIO narrow AXI-stream beats into one wide beat, little-endian;
// tlast closes a word early and m_nbeats reports how many beats it holds.
module axis_width_upsizer
  import axis_pkg::*;
#(
  parameter int IN_WIDTH = AXIS_BYTE_W,
  parameter int RATIO    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  axi_stream_if.slave                 s_axis,
  axi_stream_if.master                m_axis,
  output logic [nbeats_w(RATIO)-1:0]  m_nbeats
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int NBW       = nbeats_w(RATIO);
  localparam logic [NBW-1:0] LAST_BEAT = NBW'(RATIO - 1);

  if (RATIO < 1) begin : g_bad_ratio
    $fatal(1, "axis_width_upsizer: RATIO must be >= 1");
  end
  if ($bits(s_axis.tdata) != IN_WIDTH) begin : g_bad_in_w
    $fatal(1, "axis_width_upsizer: s_axis DATA_WIDTH must equal IN_WIDTH");
  end
  if ($bits(m_axis.tdata) != OUT_WIDTH) begin : g_bad_out_w
    $fatal(1, "axis_width_upsizer: m_axis DATA_WIDTH must equal IN_WIDTH*RATIO");
  end

  logic [RATIO-1:0][IN_WIDTH-1:0] acc;
  logic [RATIO-1:0][IN_WIDTH-1:0] merged;
  logic [NBW-1:0]                 cnt;
  logic                           in_ready;
  logic                           take;
  logic                           done;

  assign s_axis.tready = in_ready;
  assign take          = s_axis.tvalid && in_ready;
  assign done          = take && ((cnt == LAST_BEAT) || s_axis.tlast);

  // Lanes above cnt are still zero in acc, so the merge also zero-fills
  // the unused upper beats of a short word.
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    assign merged[k] = (cnt == NBW'(k)) ? s_axis.tdata : acc[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (take) begin
      if (done) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + NBW'(1);
        acc <= merged;
      end
    end
  end

  axis_out_reg #(
    .DATA_W (OUT_WIDTH),
    .NB_W   (NBW)
  ) u_out (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (done),
    .in_data    (merged),
    .in_last    (s_axis.tlast),
    .in_nbeats  (cnt + NBW'(1)),
    .in_ready   (in_ready),
    .out_valid  (m_axis.tvalid),
    .out_data   (m_axis.tdata),
    .out_last   (m_axis.tlast),
    .out_nbeats (m_nbeats),
    .out_ready  (m_axis.tready)
  );

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Bench for axis_width_upsizer: RATIO=4 and RATIO=1 instances, beat-level
// scoreboard plus directed checks of latency, backpressure and reset.
module tb_axis_width_upsizer;

  typedef struct {
    logic [31:0] d;
    logic        l;
    int          n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] nb4;
  logic [0:0] nb1;
  bit         throttle = 1'b0;

  int checks = 0;
  int passes = 0;

  exp_t        q4[$];
  exp_t        q1[$];
  logic [31:0] acc4 = '0, acc1 = '0;
  int          k4 = 0, k1 = 0;
  bit          stall4 = 1'b0;
  exp_t        hold4;

  axi_stream_if #(.DATA_WIDTH(8))  s4 ();
  axi_stream_if #(.DATA_WIDTH(32)) m4 ();
  axi_stream_if #(.DATA_WIDTH(8))  s1 ();
  axi_stream_if #(.DATA_WIDTH(8))  m1 ();

  axis_width_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut4 (
    .clk(clk), .rst(rst), .s_axis(s4), .m_axis(m4), .m_nbeats(nb4)
  );

  axis_width_upsizer #(.IN_WIDTH(8), .RATIO(1)) dut1 (
    .clk(clk), .rst(rst), .s_axis(s1), .m_axis(m1), .m_nbeats(nb1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (throttle) begin
      #1;
      m4.tready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard: beats accepted on the narrow side build expected words;
  // words accepted on the wide side are popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q4.delete(); q1.delete();
      acc4 = '0; k4 = 0; acc1 = '0; k1 = 0;
      stall4 = 1'b0;
    end else begin
      if (s4.tvalid && s4.tready) begin
        acc4[8*k4 +: 8] = s4.tdata;
        k4++;
        if (k4 == 4 || s4.tlast) begin
          q4.push_back('{acc4, s4.tlast, k4});
          acc4 = '0; k4 = 0;
        end
      end
      if (s1.tvalid && s1.tready) begin
        q1.push_back('{{24'h0, s1.tdata}, s1.tlast, 1});
      end

      if (stall4) begin
        checks++;
        if (m4.tvalid !== 1'b1 || m4.tdata !== hold4.d || m4.tlast !== hold4.l || nb4 !== 3'(hold4.n))
          $display("FAIL stall_hold4: got v=%b d=%h l=%b n=%0d, want v=1 d=%h l=%b n=%0d",
                   m4.tvalid, m4.tdata, m4.tlast, nb4, hold4.d, hold4.l, hold4.n);
        else passes++;
      end
      stall4 = m4.tvalid && !m4.tready;
      hold4  = '{m4.tdata, m4.tlast, int'(nb4)};

      if (m4.tvalid && m4.tready) begin
        checks++;
        if (q4.size() == 0) begin
          $display("FAIL sb4_unexpected: got d=%h l=%b n=%0d, want no word", m4.tdata, m4.tlast, nb4);
        end else begin
          e = q4.pop_front();
          if (m4.tdata !== e.d || m4.tlast !== e.l || nb4 !== 3'(e.n))
            $display("FAIL sb4_word: got d=%h l=%b n=%0d, want d=%h l=%b n=%0d",
                     m4.tdata, m4.tlast, nb4, e.d, e.l, e.n);
          else passes++;
        end
      end
      if (m1.tvalid && m1.tready) begin
        checks++;
        if (q1.size() == 0) begin
          $display("FAIL sb1_unexpected: got d=%h l=%b", m1.tdata, m1.tlast);
        end else begin
          e = q1.pop_front();
          if (m1.tdata !== e.d[7:0] || m1.tlast !== e.l || nb1 !== 1'(e.n))
            $display("FAIL sb1_word: got d=%h l=%b n=%0d, want d=%h l=%b n=%0d",
                     m1.tdata, m1.tlast, nb1, e.d[7:0], e.l, e.n);
          else passes++;
        end
      end
    end
  end

  // Presents one beat and returns just after the edge that accepted it.
  task automatic send(input int sel, input logic [7:0] d, input logic l, output bit first_try);
    bit ok;
    int w;
    ok = 1'b0; w = 0;
    if (sel == 0) begin s4.tvalid = 1'b1; s4.tdata = d; s4.tlast = l; end
    else          begin s1.tvalid = 1'b1; s1.tdata = d; s1.tlast = l; end
    while (!ok && w < 200) begin
      @(negedge clk);
      ok = (sel == 0) ? s4.tready : s1.tready;
      @(posedge clk); #1;
      w++;
    end
    first_try = (w == 1);
    if (!ok) begin
      checks++;
      $display("FAIL send_timeout: got no s_tready in %0d cycles, want handshake", w);
    end
  endtask

  task automatic idle();
    s4.tvalid = 1'b0; s4.tlast = 1'b0;
    s1.tvalid = 1'b0; s1.tlast = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    s4.tdata = '0; s1.tdata = '0;
    m4.tready = 1'b1; m1.tready = 1'b1;
    rst = 1'b1;
    cycles(3);
    checks++;
    if (m4.tvalid !== 1'b0 || m4.tdata !== 32'h0 || m4.tlast !== 1'b0 || nb4 !== 3'd0)
      $display("FAIL reset_out4: got v=%b d=%h l=%b n=%0d, want all 0", m4.tvalid, m4.tdata, m4.tlast, nb4);
    else passes++;
    checks++;
    if (s4.tready !== 1'b0 || s1.tready !== 1'b0)
      $display("FAIL reset_tready: got %b/%b, want 0/0", s4.tready, s1.tready);
    else passes++;
    checks++;
    if (m1.tvalid !== 1'b0 || nb1 !== 1'b0)
      $display("FAIL reset_out1: got v=%b n=%0d, want 0", m1.tvalid, nb1);
    else passes++;
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic test_full_word();
    bit ft;
    send(0, 8'h11, 1'b0, ft);
    send(0, 8'h22, 1'b0, ft);
    send(0, 8'h33, 1'b0, ft);
    checks++;
    if (m4.tvalid !== 1'b0) $display("FAIL full_early_valid: got %b, want 0", m4.tvalid);
    else passes++;
    send(0, 8'h44, 1'b1, ft);
    idle();
    checks++;
    if (m4.tvalid !== 1'b1 || m4.tdata !== 32'h44332211 || m4.tlast !== 1'b1 || nb4 !== 3'd4)
      $display("FAIL full_word: got v=%b d=%h l=%b n=%0d, want v=1 d=44332211 l=1 n=4",
               m4.tvalid, m4.tdata, m4.tlast, nb4);
    else passes++;
    cycles(1);
    checks++;
    if (m4.tvalid !== 1'b0) $display("FAIL full_drain: got %b, want 0", m4.tvalid);
    else passes++;
  endtask

  task automatic test_short_word();
    bit ft;
    send(0, 8'hAA, 1'b0, ft);
    send(0, 8'hBB, 1'b0, ft);
    send(0, 8'hCC, 1'b1, ft);
    idle();
    checks++;
    if (m4.tdata !== 32'h00CCBBAA || m4.tlast !== 1'b1 || nb4 !== 3'd3)
      $display("FAIL short_word: got d=%h l=%b n=%0d, want d=00CCBBAA l=1 n=3", m4.tdata, m4.tlast, nb4);
    else passes++;
    cycles(1);
    send(0, 8'h77, 1'b1, ft);
    idle();
    checks++;
    if (m4.tdata !== 32'h00000077 || m4.tlast !== 1'b1 || nb4 !== 3'd1)
      $display("FAIL one_beat_word: got d=%h l=%b n=%0d, want d=00000077 l=1 n=1", m4.tdata, m4.tlast, nb4);
    else passes++;
    cycles(1);
  endtask

  task automatic test_back_to_back();
    bit ft;
    int bubbles;
    bubbles = 0;
    for (int i = 1; i <= 8; i++) begin
      send(0, 8'(i), 1'b0, ft);
      if (!ft) bubbles++;
      if (i == 4) begin
        checks++;
        if (m4.tvalid !== 1'b1 || m4.tdata !== 32'h04030201 || m4.tlast !== 1'b0 || nb4 !== 3'd4)
          $display("FAIL b2b_word0: got v=%b d=%h l=%b n=%0d, want v=1 d=04030201 l=0 n=4",
                   m4.tvalid, m4.tdata, m4.tlast, nb4);
        else passes++;
      end
    end
    idle();
    checks++;
    if (m4.tvalid !== 1'b1 || m4.tdata !== 32'h08070605 || nb4 !== 3'd4)
      $display("FAIL b2b_word1: got v=%b d=%h n=%0d, want v=1 d=08070605 n=4", m4.tvalid, m4.tdata, nb4);
    else passes++;
    checks++;
    if (bubbles !== 0) $display("FAIL b2b_bubbles: got %0d stalls, want 0", bubbles);
    else passes++;
    cycles(1);
  endtask

  task automatic test_backpressure();
    bit ft;
    m4.tready = 1'b0;
    send(0, 8'hA1, 1'b0, ft);
    send(0, 8'hA2, 1'b0, ft);
    send(0, 8'hA3, 1'b0, ft);
    send(0, 8'hA4, 1'b0, ft);
    s4.tdata = 8'hA5;
    cycles(3);
    checks++;
    if (m4.tvalid !== 1'b1 || s4.tready !== 1'b0 || m4.tdata !== 32'hA4A3A2A1 || nb4 !== 3'd4)
      $display("FAIL bp_hold: got v=%b sr=%b d=%h n=%0d, want v=1 sr=0 d=A4A3A2A1 n=4",
               m4.tvalid, s4.tready, m4.tdata, nb4);
    else passes++;
    m4.tready = 1'b1;
    #1;
    checks++;
    if (s4.tready !== 1'b1) $display("FAIL bp_release_tready: got %b, want 1", s4.tready);
    else passes++;
    send(0, 8'hA5, 1'b1, ft);
    idle();
    checks++;
    if (m4.tvalid !== 1'b1 || m4.tdata !== 32'h000000A5 || nb4 !== 3'd1)
      $display("FAIL bp_next_word: got v=%b d=%h n=%0d, want v=1 d=000000A5 n=1", m4.tvalid, m4.tdata, nb4);
    else passes++;
    cycles(1);
  endtask

  task automatic test_reset_mid();
    bit ft;
    m4.tready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 8'hE0 + 8'(i), 1'b0, ft);
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (s4.tready !== 1'b0) $display("FAIL rst_tready: got %b, want 0", s4.tready);
    else passes++;
    cycles(1);
    checks++;
    if (m4.tvalid !== 1'b0 || m4.tdata !== 32'h0 || m4.tlast !== 1'b0 || nb4 !== 3'd0)
      $display("FAIL rst_mid_output: got v=%b d=%h l=%b n=%0d, want all 0", m4.tvalid, m4.tdata, m4.tlast, nb4);
    else passes++;
    rst = 1'b0;
    m4.tready = 1'b1;
    send(0, 8'hF1, 1'b0, ft);
    send(0, 8'hF2, 1'b0, ft);
    idle();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 8'h0D + 8'(i), 1'b0, ft);
    idle();
    checks++;
    if (m4.tvalid !== 1'b1 || m4.tdata !== 32'h100F0E0D || nb4 !== 3'd4)
      $display("FAIL rst_mid_word: got v=%b d=%h n=%0d, want v=1 d=100F0E0D n=4", m4.tvalid, m4.tdata, nb4);
    else passes++;
    cycles(1);
  endtask

  task automatic test_ratio1();
    bit ft;
    send(1, 8'h5A, 1'b0, ft);
    checks++;
    if (m1.tvalid !== 1'b1 || m1.tdata !== 8'h5A || m1.tlast !== 1'b0 || nb1 !== 1'b1)
      $display("FAIL r1_first: got v=%b d=%h l=%b n=%0d, want v=1 d=5A l=0 n=1", m1.tvalid, m1.tdata, m1.tlast, nb1);
    else passes++;
    send(1, 8'hA5, 1'b1, ft);
    idle();
    checks++;
    if (m1.tvalid !== 1'b1 || m1.tdata !== 8'hA5 || m1.tlast !== 1'b1 || nb1 !== 1'b1)
      $display("FAIL r1_second: got v=%b d=%h l=%b n=%0d, want v=1 d=A5 l=1 n=1", m1.tvalid, m1.tdata, m1.tlast, nb1);
    else passes++;
    cycles(2);
  endtask

  task automatic test_random();
    bit ft;
    int w;
    throttle = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        cycles($urandom_range(1, 2));
      end
      send(0, 8'($urandom), 1'($urandom_range(0, 7) == 0), ft);
    end
    idle();
    throttle = 1'b0;
    cycles(2);
    #1;
    m4.tready = 1'b1;
    // Flush any partial word with a closing beat so the scoreboard empties.
    send(0, 8'h5C, 1'b1, ft);
    idle();
    w = 0;
    while ((q4.size() != 0 || m4.tvalid) && w < 100) begin
      cycles(1);
      w++;
    end
    checks++;
    if (q4.size() != 0 || q1.size() != 0)
      $display("FAIL rand_drain: got %0d/%0d words outstanding, want 0/0", q4.size(), q1.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_short_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_ratio1();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
